// File: rtl/nt_candidate_gen_if.sv
// Candidate stream bundle between the generator and the hash stage.
// Master presents a candidate; slave accepts it with cand_ready.
interface nt_candidate_gen_if #(
    parameter int MAX_LEN = 8
);
    logic                   cand_valid;
    logic                   cand_ready;
    logic [3:0]             cand_len;
    logic [8*MAX_LEN-1:0]   cand_chars;

    modport master (
        output cand_valid,
        output cand_len,
        output cand_chars,
        input  cand_ready
    );

    modport slave (
        input  cand_valid,
        input  cand_len,
        input  cand_chars,
        output cand_ready
    );
endinterface

// File: rtl/nt_candidate_gen.sv
// Odometer enumerator over the 62-symbol charset, MIN_LEN..MAX_LEN.
// Emits one candidate per handshake; every output is a flop.
module nt_candidate_gen #(
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    nt_candidate_gen_if.master cand,
    output logic busy,
    output logic done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] MIN_L = 4'(MIN_LEN);
    localparam logic [3:0] MAX_L = 4'(MAX_LEN);

    logic [1:0]           state;
    logic [1:0]           state_n;
    logic [3:0]           len;
    logic [3:0]           len_n;
    logic [5:0]           idx   [MAX_LEN];
    logic [5:0]           idx_n [MAX_LEN];
    logic [8*MAX_LEN-1:0] chars;
    logic [8*MAX_LEN-1:0] chars_n;
    logic                 valid;
    logic                 carry;

    function automatic logic [7:0] to_ascii(input logic [5:0] d);
        logic [7:0] w;
        w = {2'b00, d};
        if (d < 6'd10)
            return 8'h30 + w;
        else if (d < 6'd36)
            return 8'h57 + w;
        else
            return 8'h1d + w;
    endfunction

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        carry   = 1'b0;
        if (abort) begin
            state_n = IDLE;
            len_n   = '0;
            for (int i = 0; i < MAX_LEN; i++)
                idx_n[i] = '0;
        end else begin
            case (state)
                RUN: begin
                    if (valid && cand.cand_ready) begin
                        carry = 1'b1;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (carry && (4'(i) < len)) begin
                                if (idx[i] == 6'd61) begin
                                    idx_n[i] = '0;
                                end else begin
                                    idx_n[i] = idx[i] + 6'd1;
                                    carry    = 1'b0;
                                end
                            end
                        end
                        // Carry out of the top digit: grow or finish.
                        if (carry) begin
                            if (len == MAX_L) begin
                                state_n = DONE;
                                idx_n   = idx;
                            end else begin
                                len_n = len + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_n = RUN;
                        len_n   = MIN_L;
                        for (int i = 0; i < MAX_LEN; i++)
                            idx_n[i] = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        chars_n = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (4'(i) < len_n)
                chars_n[8*i +: 8] = to_ascii(idx_n[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len   <= '0;
            chars <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++)
                idx[i] <= '0;
        end else begin
            state <= state_n;
            len   <= len_n;
            chars <= chars_n;
            valid <= (state_n == RUN);
            busy  <= (state_n == RUN);
            done  <= (state_n == DONE);
            for (int i = 0; i < MAX_LEN; i++)
                idx[i] <= idx_n[i];
        end
    end

    assign cand.cand_valid = valid;
    assign cand.cand_len   = len;
    assign cand.cand_chars = chars;
endmodule
